// File: rtl/display_pkg.sv
// Shared constants for the output-register decimal display: segment
// encodings, converter FSM states and the double-dabble step count.
package display_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

  localparam int         STEPS     = 8;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  // {g,f,e,d,c,b,a}; anything above 9 renders blank
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble: one capture cycle, eight shift steps, one load
// cycle. done pulses in the load state while the BCD outputs are final.
module bin_to_bcd
  import display_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] value,
  input  logic       signed_mode,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       neg,
  output logic       busy,
  output logic       done
);
  state_t      state, state_n;
  logic [2:0]  step;
  logic [7:0]  mag;
  logic [11:0] bcd, adj;
  logic        neg_q;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    adj     = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_CONV;
      S_CONV:  if (step == 3'(STEPS - 1)) state_n = S_LOAD;
      S_LOAD:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      step  <= '0;
      mag   <= '0;
      bcd   <= '0;
      neg_q <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (start) begin
          // 8'h80 negates to itself, which reads correctly as 128 unsigned
          mag   <= (signed_mode && value[7]) ? 8'(~value + 8'd1) : value;
          neg_q <= signed_mode && value[7];
          bcd   <= '0;
          step  <= '0;
        end
        S_CONV: begin
          {bcd, mag} <= {adj[10:0], mag, 1'b0};
          step       <= step + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign hundreds = bcd[11:8];
  assign tens     = bcd[7:4];
  assign ones     = bcd[3:0];
  assign neg      = neg_q;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_LOAD);
endmodule

// File: rtl/out_display.sv
// Decimal display driver: reconverts only on a change of {signed_mode,value},
// holds the finished digits, and scans them onto a 4-digit 7-segment display.
module out_display
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       signed_mode,
  output logic [6:0] seg,
  output logic [3:0] digit_en,
  output logic       busy,
  output logic [7:0] shown
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [8:0]    cur, last_pair;
  logic          start, done, neg;
  logic [3:0]    hundreds, tens, ones;
  logic [3:0]    d_h, d_t, d_o;
  logic          d_neg;
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [3:0][6:0] pat;

  assign cur   = {signed_mode, value};
  assign start = (cur != last_pair) && !busy;

  bin_to_bcd u_conv (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .value      (value),
    .signed_mode(signed_mode),
    .hundreds   (hundreds),
    .tens       (tens),
    .ones       (ones),
    .neg        (neg),
    .busy       (busy),
    .done       (done)
  );

  // last_pair doubles as the captured value that becomes `shown` on load
  always_ff @(posedge clk) begin
    if (reset) begin
      last_pair <= '0;
      d_h       <= '0;
      d_t       <= '0;
      d_o       <= '0;
      d_neg     <= 1'b0;
      shown     <= '0;
    end else begin
      if (start) last_pair <= cur;
      if (done) begin
        d_h   <= hundreds;
        d_t   <= tens;
        d_o   <= ones;
        d_neg <= neg;
        shown <= last_pair[7:0];
      end
    end
  end

  always_comb begin
    pat[0] = seg_of(d_o);
    pat[1] = (d_h == 4'd0 && d_t == 4'd0) ? SEG_BLANK : seg_of(d_t);
    pat[2] = (d_h == 4'd0) ? SEG_BLANK : seg_of(d_h);
    pat[3] = d_neg ? SEG_MINUS : SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      idx      <= '0;
      seg      <= 7'h3F;
      digit_en <= 4'b0001;
    end else begin
      if (presc == PW'(REFRESH_DIV - 1)) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + PW'(1);
      end
      seg      <= pat[idx];
      digit_en <= 4'b0001 << idx;
    end
  end
endmodule

// File: tb/tb_out_display.sv
// Scoreboard bench: stimulus queues the expected result, a monitor checks
// shown, busy length and the scanned digits whenever a conversion completes.
module tb_out_display;
  localparam int DIV = 4;

  logic       clk = 1'b0, reset = 1'b1, signed_mode = 1'b0;
  logic [7:0] value = 8'h00;
  logic [6:0] seg;
  logic [3:0] digit_en;
  logic       busy;
  logic [7:0] shown;

  typedef struct {
    logic [7:0]      shown;
    logic            chk;
    logic [3:0][6:0] segs;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0, nfail = 0, ndone = 0;

  out_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .value(value), .signed_mode(signed_mode),
    .seg(seg), .digit_en(digit_en), .busy(busy), .shown(shown)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one full scan plus margin, recording the pattern seen for each digit
  task automatic scan(output logic [3:0][6:0] got);
    got = 'x;
    repeat (4 * DIV + 4) begin
      @(negedge clk);
      case (digit_en)
        4'b0001: got[0] = seg;
        4'b0010: got[1] = seg;
        4'b0100: got[2] = seg;
        4'b1000: got[3] = seg;
        default: ;
      endcase
    end
  endtask

  task automatic push(input logic [7:0] sh, input logic chk, input logic [3:0][6:0] segs);
    exp_t e;
    e.shown = sh; e.chk = chk; e.segs = segs;
    sb.push_back(e);
  endtask

  task automatic apply(input logic sm, input logic [7:0] v, input logic [3:0][6:0] segs);
    push(v, 1'b1, segs);
    @(posedge clk); #1;
    signed_mode = sm;
    value       = v;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (ndone < target && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (ndone < target) begin
      nvec++; nfail++;
      $display("FAIL timeout: completions %0d expected %0d", ndone, target);
    end
  endtask

  // monitor
  initial begin
    int bc = 0;
    exp_t e;
    logic [3:0][6:0] g;
    forever begin
      @(negedge clk);
      if (reset) bc = 0;
      else if (busy) bc++;
      else if (bc > 0) begin
        if (sb.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL unexpected_done: shown %0h with empty scoreboard", shown);
        end else begin
          e = sb.pop_front();
          check("shown", shown, e.shown);
          check("busy_cycles", bc, 9);
          if (e.chk) begin
            scan(g);
            for (int d = 0; d < 4; d++)
              check($sformatf("digit%0d(shown %0h)", d, e.shown), g[d], e.segs[d]);
          end
        end
        bc = 0;
        ndone++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0][6:0] g;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_digit_en", digit_en, 4'b0001);
    check("rst_seg", seg, 7'h3F);
    check("rst_busy", busy, 1'b0);
    check("rst_shown", shown, 8'h00);
    @(posedge clk); #1 reset = 1'b0;
    scan(g);
    check("idle_digit3", g[3], 7'h00);
    check("idle_digit2", g[2], 7'h00);
    check("idle_digit1", g[1], 7'h00);
    check("idle_digit0", g[0], 7'h3F);
    check("idle_busy", busy, 1'b0);

    apply(1'b0, 8'd233, {7'h00, 7'h5B, 7'h4F, 7'h4F}); wait_done(1);
    apply(1'b1, 8'hF9,  {7'h40, 7'h00, 7'h00, 7'h07}); wait_done(2);
    apply(1'b1, 8'h80,  {7'h40, 7'h06, 7'h5B, 7'h7F}); wait_done(3);
    apply(1'b0, 8'h80,  {7'h00, 7'h06, 7'h5B, 7'h7F}); wait_done(4);

    // change during conversion: 10 finishes first, 20 captured at E10
    push(8'd10, 1'b0, '0);
    push(8'd20, 1'b1, {7'h00, 7'h00, 7'h5B, 7'h3F});
    @(posedge clk); #1 value = 8'd10;
    repeat (3) @(posedge clk);
    #1 value = 8'd20;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("recapture_busy", busy, 1'b1);
    check("recapture_shown", shown, 8'd10);
    wait_done(6);

    // reset at E4 abandons 99; it reconverts once reset drops
    push(8'd99, 1'b1, {7'h00, 7'h00, 7'h6F, 7'h6F});
    @(posedge clk); #1 value = 8'd99;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_shown", shown, 8'h00);
    check("midrst_seg", seg, 7'h3F);
    check("midrst_digit_en", digit_en, 4'b0001);
    @(posedge clk); #1 reset = 1'b0;
    wait_done(7);

    repeat (5) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
